// File: rtl/music_pkg.sv
// music_pkg: shared note codes, nominal period table and decoder FSM states.
//   Note codes are {high,med,low} nibbles; E0 (12'h000) means silence.
//   ORIGIN mirrors the tone generator's origin table; nominal period in ticks is
//   2*(16384-origin). DEGLITCH_CYC is used only when DECODER_DEGLITCH_EN is defined.
package music_pkg;
  localparam logic [11:0] E0 = 12'h000;
  localparam logic [11:0] L1 = 12'h001, L2 = 12'h002, L3 = 12'h003, L4 = 12'h004,
                          L5 = 12'h005, L6 = 12'h006, L7 = 12'h007;
  localparam logic [11:0] M1 = 12'h010, M2 = 12'h020, M3 = 12'h030, M4 = 12'h040,
                          M5 = 12'h050, M6 = 12'h060, M7 = 12'h070;
  localparam logic [11:0] H1 = 12'h100, H2 = 12'h200, H3 = 12'h300, H4 = 12'h400,
                          H5 = 12'h500, H6 = 12'h600, H7 = 12'h700;
  localparam int NOTES = 21;
  localparam int DEGLITCH_CYC = 4;
  localparam logic [11:0] CODE [NOTES] = '{L1, L2, L3, L4, L5, L6, L7,
                                           M1, M2, M3, M4, M5, M6, M7,
                                           H1, H2, H3, H4, H5, H6, H7};
  localparam int ORIGIN [NOTES] = '{4933, 6168, 7281, 7791, 8730, 9565, 10310,
                                    10647, 11272, 11831, 12094, 12556, 12974, 13346,
                                    13516, 13829, 14108, 14235, 14470, 14678, 14858};
  typedef enum logic [1:0] {SILENT, ACQUIRE, LOCKED} state_t;
  function automatic logic [15:0] nom(int n);
    return 16'(2 * (16384 - ORIGIN[n]));
  endfunction
endpackage

// File: rtl/music_period_meter.sv
// music_period_meter: synchronises audio, optionally deglitches it, detects rising
//   edges and measures the rise-to-rise period in prescaled ticks.
//   Optional feature macro: DECODER_DEGLITCH_EN (level filter of DEGLITCH_CYC clk).
//   Ports: clk, rst (async, active high), enable (0 clears counters, blocks edges),
//          audio (async tone), period_strobe (1 clk per edge), period (ticks),
//          timeout (1 clk when the counter first reaches SILENCE_TICKS).
module music_period_meter import music_pkg::*; #(
  parameter int CLK_DIV = 8,
  parameter int SILENCE_TICKS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        audio,
  output logic        period_strobe,
  output logic        timeout,
  output logic [15:0] period
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [1:0] sync;
  logic lvl, lvl_q, rise, tick;
  logic [PW-1:0] pre;
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else sync <= {sync[0], audio};
`ifdef DECODER_DEGLITCH_EN
  localparam int DW = $clog2(DEGLITCH_CYC + 1);
  logic [DW-1:0] dcnt;
  logic filt;
  // the filtered level follows only after DEGLITCH_CYC consecutive differing samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      filt <= 1'b0;
      dcnt <= '0;
    end else if (sync[1] == filt) dcnt <= '0;
    else if (dcnt == DW'(DEGLITCH_CYC - 1)) begin
      filt <= sync[1];
      dcnt <= '0;
    end else dcnt <= dcnt + 1'b1;
  assign lvl = filt;
`else
  assign lvl = sync[1];
`endif
  assign rise = enable & lvl & ~lvl_q;
  assign tick = pre == PW'(CLK_DIV - 1);
  // an edge restarts the count, so an edge and a timeout never coincide
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lvl_q <= 1'b0;
      pre <= '0;
      cnt <= '0;
      period <= '0;
      period_strobe <= 1'b0;
      timeout <= 1'b0;
    end else begin
      lvl_q <= lvl;
      period_strobe <= rise;
      timeout <= 1'b0;
      if (!enable) begin
        pre <= '0;
        cnt <= '0;
      end else if (rise) begin
        period <= cnt;
        pre <= '0;
        cnt <= '0;
      end else begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick && cnt != 16'(SILENCE_TICKS)) begin
          cnt <= cnt + 1'b1;
          timeout <= cnt == 16'(SILENCE_TICKS - 1);
        end
      end
    end
endmodule

// File: rtl/music_note_decoder.sv
// music_note_decoder: maps the period of a square-wave tone to a 12-bit note code.
//   Optional feature macro: DECODER_DEGLITCH_EN (passed through to the period meter).
//   Ports: clk, rst (async, active high), enable_decoder (0 = hold SILENT),
//          audio (async tone), note_code ({high,med,low}, E0 = silence),
//          note_valid (1 clk when note_code changes), note_locked (two matching
//          periods confirmed), period (last full period in ticks).
module music_note_decoder import music_pkg::*; #(
  parameter int CLK_DIV = 8,
  parameter int TOL = 64,
  parameter int SILENCE_TICKS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_decoder,
  input  logic        audio,
  output logic [11:0] note_code,
  output logic        note_valid,
  output logic        note_locked,
  output logic [15:0] period
);
  logic strobe, timeout, hit_strobe, lock;
  logic [11:0] match, hit, cand, cand_n, code_n;
  state_t state, state_n;
  music_period_meter #(.CLK_DIV(CLK_DIV), .SILENCE_TICKS(SILENCE_TICKS)) u_meter (
    .clk(clk),
    .rst(rst),
    .enable(enable_decoder),
    .audio(audio),
    .period_strobe(strobe),
    .timeout(timeout),
    .period(period)
  );
  always_comb begin
    match = E0;
    for (int i = 0; i < NOTES; i++)
      if ((period >= nom(i) ? period - nom(i) : nom(i) - period) <= 16'(TOL)) match = CODE[i];
  end
  // in LOCKED the candidate equals note_code, so one rule serves ACQUIRE and LOCKED
  assign lock = hit != E0 && hit == cand;
  assign note_locked = state == LOCKED;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SILENT;
      cand <= E0;
      note_code <= E0;
      note_valid <= 1'b0;
      hit <= E0;
      hit_strobe <= 1'b0;
    end else begin
      state <= state_n;
      cand <= cand_n;
      note_code <= code_n;
      note_valid <= code_n != note_code;
      hit <= match;
      hit_strobe <= strobe;
    end
  always_comb begin
    state_n = state;
    cand_n = cand;
    code_n = note_code;
    if (!enable_decoder || timeout) begin
      state_n = SILENT;
      cand_n = E0;
      code_n = E0;
    end else if (hit_strobe) begin
      // the first edge out of SILENT only arms the period counter
      state_n = state == SILENT || !lock ? ACQUIRE : LOCKED;
      cand_n = state == SILENT ? E0 : hit;
      code_n = state != SILENT && lock ? hit : note_code;
    end
  end
endmodule
